// File: rtl/piso_shift_register_pkg.sv
// Shared types and sizing helpers for the serial LED link (PISO transmitter and SIPO receiver).
// Word length is common to both ends, so the default lives here.
package piso_shift_register_pkg;

  localparam int DEFAULT_WIDTH = 10;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  // Counter must hold WIDTH itself, not just WIDTH-1.
  function automatic int cnt_width(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/piso_shift_register_if.sv
// Word-source <-> serialiser bundle: load/enable requests in, serial stream and status out.
// master = word source / FSM logic, slave = piso_shift_register.
interface piso_shift_register_if
  import piso_shift_register_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
);

  logic [WIDTH-1:0] i_data;
  logic             i_load;
  logic             i_en;
  logic             o_ready;
  logic             o_ser;
  logic             o_ser_valid;
  logic             o_last;
  logic             o_busy;

  modport master (
    output i_data, i_load, i_en,
    input  o_ready, o_ser, o_ser_valid, o_last, o_busy
  );

  modport slave (
    input  i_data, i_load, i_en,
    output o_ready, o_ser, o_ser_valid, o_last, o_busy
  );

endinterface

// File: rtl/piso_bit_counter.sv
// Loadable down-counter of bits remaining in a frame; load wins over decrement, stops at 0.
// Zero latency on the is_one flag (decoded from the registered count).
module piso_bit_counter #(
  parameter int WIDTH = 10,
  parameter int CNT_W = 4
) (
  input  logic clk,
  input  logic resetn,
  input  logic load,
  input  logic dec,
  output logic is_one
);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= CNT_W'(WIDTH);
    end else if (dec && (cnt != '0)) begin
      cnt <= cnt - CNT_W'(1);
    end
  end

  assign is_one = (cnt == CNT_W'(1));

endmodule

// File: rtl/piso_shift_register.sv
// Parallel-in serial-out transmitter: first bit appears 1 cycle after accept, then one bit per i_en tick.
// o_ready only in IDLE or on the final enabled bit, which lets frames run back-to-back without a gap.
module piso_shift_register
  import piso_shift_register_pkg::*;
#(
  parameter int WIDTH     = DEFAULT_WIDTH,
  parameter bit MSB_FIRST = 1'b1,
  parameter bit IDLE_VAL  = 1'b0
) (
  input logic                 clk,
  input logic                 resetn,
  piso_shift_register_if.slave bus
);

  localparam int CNT_W = cnt_width(WIDTH);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic             ser_q, ser_d;
  logic             vld_q, vld_d;
  logic             cnt_one;
  logic             advance;
  logic             accept;

  assign advance     = (state_q == SHIFT) && bus.i_en;
  assign bus.o_ready = resetn && ((state_q == IDLE) || (advance && cnt_one));
  assign accept      = bus.i_load && bus.o_ready;

  piso_bit_counter #(
    .WIDTH (WIDTH),
    .CNT_W (CNT_W)
  ) u_bit_counter (
    .clk    (clk),
    .resetn (resetn),
    .load   (accept),
    .dec    (advance),
    .is_one (cnt_one)
  );

  // The bit on o_ser is always the head of shreg_q; shifting exposes the next one.
  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    ser_d   = ser_q;
    vld_d   = vld_q;
    if (accept) begin
      state_d = SHIFT;
      shreg_d = bus.i_data;
      ser_d   = MSB_FIRST ? bus.i_data[WIDTH-1] : bus.i_data[0];
      vld_d   = 1'b1;
    end else if (advance) begin
      if (cnt_one) begin
        state_d = IDLE;
        shreg_d = '0;
        ser_d   = IDLE_VAL;
        vld_d   = 1'b0;
      end else if (MSB_FIRST) begin
        shreg_d = {shreg_q[WIDTH-2:0], 1'b0};
        ser_d   = shreg_q[WIDTH-2];
      end else begin
        shreg_d = {1'b0, shreg_q[WIDTH-1:1]};
        ser_d   = shreg_q[1];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q <= IDLE;
      shreg_q <= '0;
      ser_q   <= IDLE_VAL;
      vld_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      ser_q   <= ser_d;
      vld_q   <= vld_d;
    end
  end

  assign bus.o_ser       = ser_q;
  assign bus.o_ser_valid = vld_q;
  assign bus.o_last      = vld_q && cnt_one;
  assign bus.o_busy      = (state_q == SHIFT);

endmodule
